// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//
// Shared types and default sizing for the unified-memory port arbiter that
// sits between the instruction-fetch and data-memory stages of the pipelined
// MIPS core.
//
// Contents:
//   DEF_ADDR_W, DEF_DATA_W    default word-address and data widths
//   DEF_STARVE_MAX            default fetch starvation limit
//   DEF_TIMEOUT               default memory acknowledge timeout (cycles)
//   arb_state_e               arbiter FSM states
//   grant_e                   which requester owns the current transaction
// ---------------------------------------------------------------------------
package mem_arb_pkg;

   localparam int DEF_ADDR_W     = 16;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_STARVE_MAX = 4;
   localparam int DEF_TIMEOUT    = 64;

   // IDLE arbitrates, SERVE_x waits on the memory, RESP issues the ready pulse.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SERVE_IF = 2'd1,
      SERVE_DM = 2'd2,
      RESP     = 2'd3
   } arb_state_e;

   // Owner of the transaction in flight, kept so the completion logic can
   // route read data and ready without re-decoding the state.
   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } grant_e;

endpackage

// File: rtl/arb_watchdog.sv
// ---------------------------------------------------------------------------
// arb_watchdog
//
// Loadable down-counter used by the arbiter to bound how long a memory
// transaction may wait for its acknowledge.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-low
//   clear       forces the count to zero
//   load        loads load_value (ignored while clear is high)
//   load_value  value loaded on load
//   enable      counts down by one per cycle while high and non-zero
//   expire      combinational pulse: enable is high and the count is zero
// ---------------------------------------------------------------------------
module arb_watchdog #(
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             enable,
   output logic             expire
);

   logic [CNT_W-1:0] count;

   // The counter is loaded with (limit - 1) so that expire fires during the
   // last allowed wait cycle.  It parks at zero rather than wrapping, so a
   // long-enabled but already-expired watchdog keeps reporting expiry.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   // Expiry is only meaningful while the owner is actually waiting.
   assign expire = enable && (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port unified memory between instruction fetch (IF) and
// data-memory access (MEM).  Each access is run as a req/ack transaction
// against a variable-latency memory; read data and a one-cycle ready pulse
// are returned to the winning requester.  Data accesses have priority, but a
// starvation counter forces a fetch grant after STARVE_MAX consecutive data
// grants made while fetch was waiting.  A watchdog aborts a transaction that
// never receives mem_ack.
//
// Ports:
//   clk, rst                 clock and synchronous active-low reset
//   if_req, if_addr          fetch request (held until if_ready) and address
//   if_rdata, if_ready       registered fetch data and completion pulse
//   dm_req, dm_we, dm_addr,
//   dm_wdata                 data request (held until dm_ready) and payload
//   dm_rdata, dm_ready       registered load data and completion pulse
//   mem_req, mem_we,
//   mem_addr, mem_wdata      memory request, held stable until mem_ack
//   mem_rdata, mem_ack       memory read data and single-cycle completion
//   stall_if, stall_mem      per-stage stalls to the hazard unit
//   err_timeout              sticky flag, set when a transaction times out
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int STARVE_MAX = DEF_STARVE_MAX,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,

   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ready,

   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,

   output logic              stall_if,
   output logic              stall_mem,
   output logic              err_timeout
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam int ST_W = $clog2(STARVE_MAX + 1);

   localparam logic [WD_W-1:0] WD_LOAD   = WD_W'(TIMEOUT - 1);
   localparam logic [ST_W-1:0] ST_LIMIT  = ST_W'(STARVE_MAX);

   arb_state_e       state;
   grant_e           grant;
   logic [ST_W-1:0]  starve_cnt;

   logic             grant_dm;
   logic             grant_if;
   logic             in_serve;
   logic             wd_load;
   logic             wd_clear;
   logic             wd_expire;

   // Arbitration decision, only acted upon in IDLE.  Data wins unless fetch
   // is waiting and has already been passed over STARVE_MAX times in a row.
   always_comb begin
      grant_dm = 1'b0;
      grant_if = 1'b0;
      if (dm_req && (!if_req || (starve_cnt < ST_LIMIT))) begin
         grant_dm = 1'b1;
      end else if (if_req) begin
         grant_if = 1'b1;
      end
   end

   // The watchdog is armed at every grant, counts only while waiting on the
   // memory and is parked again in the response cycle.
   assign in_serve = (state == SERVE_IF) || (state == SERVE_DM);
   assign wd_load  = (state == IDLE) && (grant_dm || grant_if);
   assign wd_clear = (state == RESP);

   arb_watchdog #(
      .CNT_W (WD_W)
   ) u_watchdog (
      .clk        (clk),
      .rst        (rst),
      .clear      (wd_clear),
      .load       (wd_load),
      .load_value (WD_LOAD),
      .enable     (in_serve),
      .expire     (wd_expire)
   );

   // Main transaction FSM.  All memory-side and requester-side outputs are
   // registered here.  The request payload is captured only at grant time so
   // a requester changing its address mid-transaction cannot disturb the
   // memory.  mem_we is dropped together with mem_req so it never appears
   // outside a request.  A mem_ack outside SERVE (for example one left over
   // from a transaction abandoned by reset) is simply ignored.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         grant       <= GNT_IF;
         starve_cnt  <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         if_rdata    <= '0;
         dm_rdata    <= '0;
         if_ready    <= 1'b0;
         dm_ready    <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_dm) begin
                  mem_req   <= 1'b1;
                  mem_we    <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  grant     <= GNT_DM;
                  state     <= SERVE_DM;
                  if (!if_req) begin
                     starve_cnt <= '0;
                  end else if (starve_cnt < ST_LIMIT) begin
                     starve_cnt <= starve_cnt + 1'b1;
                  end
               end else if (grant_if) begin
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_addr   <= if_addr;
                  grant      <= GNT_IF;
                  state      <= SERVE_IF;
                  starve_cnt <= '0;
               end else begin
                  starve_cnt <= '0;
               end
            end

            SERVE_IF, SERVE_DM: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state   <= RESP;
                  if (grant == GNT_IF) begin
                     if_rdata <= mem_rdata;
                     if_ready <= 1'b1;
                  end else begin
                     if (!mem_we) begin
                        dm_rdata <= mem_rdata;
                     end
                     dm_ready <= 1'b1;
                  end
               end else if (wd_expire) begin
                  mem_req     <= 1'b0;
                  mem_we      <= 1'b0;
                  state       <= RESP;
                  err_timeout <= 1'b1;
                  if (grant == GNT_IF) begin
                     if_rdata <= '0;
                     if_ready <= 1'b1;
                  end else begin
                     dm_rdata <= '0;
                     dm_ready <= 1'b1;
                  end
               end
            end

            RESP: begin
               if_ready <= 1'b0;
               dm_ready <= 1'b0;
               state    <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Stalls follow the live request so a request arriving while another
   // transaction is in flight stalls its stage immediately.
   assign stall_if  = if_req & ~if_ready;
   assign stall_mem = dm_req & ~dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter.  A transaction-level model predicts
// every output each cycle; a memory responder answers mem_req after a
// programmable delay (or never).  Literal expectations pin the key cases.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 4;
   localparam int TIMEOUT    = 64;

   logic              clk;
   logic              rst;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_ready;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              stall_if;
   logic              stall_mem;
   logic              err_timeout;

   mem_port_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .STARVE_MAX (STARVE_MAX),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .if_rdata    (if_rdata),
      .if_ready    (if_ready),
      .dm_req      (dm_req),
      .dm_we       (dm_we),
      .dm_addr     (dm_addr),
      .dm_wdata    (dm_wdata),
      .dm_rdata    (dm_rdata),
      .dm_ready    (dm_ready),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .stall_if    (stall_if),
      .stall_mem   (stall_mem),
      .err_timeout (err_timeout)
   );

   // Free-running clock, first rising edge at 5.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_on   = 0;

   // Transaction-level model: one open transaction record plus expected outputs.
   bit                m_open     = 0;
   bit                m_resp     = 0;
   bit                m_in_reset = 1;
   bit                m_is_dm    = 0;
   bit                m_we       = 0;
   logic [ADDR_W-1:0] m_addr     = '0;
   logic [DATA_W-1:0] m_wdata    = '0;
   int                m_age      = 0;
   int                m_starve   = 0;
   int                m_grants[$];
   logic              e_mem_req  = 0;
   logic              e_if_ready = 0;
   logic              e_dm_ready = 0;
   logic [DATA_W-1:0] e_if_rdata = '0;
   logic [DATA_W-1:0] e_dm_rdata = '0;
   logic              e_err      = 0;

   // Memory responder settings (ack_delay < 0 means never acknowledge).
   int                ack_delay  = 0;
   int                resp_cnt   = 0;
   bit                resp_done  = 0;
   logic [DATA_W-1:0] resp_data  = '0;

   int                gnt_log[$];
   bit                seen_req;
   logic              first_we;
   logic [ADDR_W-1:0] first_addr;

   task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                              input logic [DATA_W-1:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic ir, input logic [ADDR_W-1:0] ia,
                                input logic dr, input logic dw,
                                input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd);
      if_req   = ir;
      if_addr  = ia;
      dm_req   = dr;
      dm_we    = dw;
      dm_addr  = da;
      dm_wdata = dd;
   endtask

   // Advance the model across one rising edge using the inputs as sampled there.
   task automatic modelUpdate();
      if (!rst) begin
         m_open = 0; m_resp = 0; m_in_reset = 1; m_age = 0; m_starve = 0;
         e_mem_req = 0; e_if_ready = 0; e_dm_ready = 0;
         e_if_rdata = '0; e_dm_rdata = '0; e_err = 0;
      end else begin
         m_in_reset = 0;
         if (m_resp) begin
            m_resp = 0; e_if_ready = 0; e_dm_ready = 0;
         end else if (m_open) begin
            m_age++;
            if (mem_ack || m_age == TIMEOUT) begin
               m_open = 0; m_resp = 1; e_mem_req = 0;
               if (m_is_dm) e_dm_ready = 1; else e_if_ready = 1;
               if (mem_ack) begin
                  if (!m_is_dm) e_if_rdata = mem_rdata;
                  else if (!m_we) e_dm_rdata = mem_rdata;
               end else begin
                  if (m_is_dm) e_dm_rdata = '0; else e_if_rdata = '0;
                  e_err = 1;
               end
            end
         end else begin
            if (dm_req && (!if_req || m_starve < STARVE_MAX)) begin
               m_open = 1; m_is_dm = 1; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
               m_starve = if_req ? ((m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1) : 0;
            end else if (if_req) begin
               m_open = 1; m_is_dm = 0; m_we = 0; m_addr = if_addr;
               m_starve = 0;
            end else begin
               m_starve = 0;
            end
            if (m_open) begin
               m_age = 0; e_mem_req = 1;
               m_grants.push_back(m_is_dm ? 1 : 0);
            end
         end
      end
   endtask

   // Compare every output against the model.
   task automatic compareModel();
      checkOutput("mem_req", {31'd0, mem_req}, {31'd0, e_mem_req});
      checkOutput("if_ready", {31'd0, if_ready}, {31'd0, e_if_ready});
      checkOutput("dm_ready", {31'd0, dm_ready}, {31'd0, e_dm_ready});
      checkOutput("if_rdata", if_rdata, e_if_rdata);
      checkOutput("dm_rdata", dm_rdata, e_dm_rdata);
      checkOutput("err_timeout", {31'd0, err_timeout}, {31'd0, e_err});
      checkOutput("stall_if", {31'd0, stall_if}, {31'd0, if_req & ~e_if_ready});
      checkOutput("stall_mem", {31'd0, stall_mem}, {31'd0, dm_req & ~e_dm_ready});
      if (e_mem_req) begin
         checkOutput("mem_addr", {16'd0, mem_addr}, {16'd0, m_addr});
         checkOutput("mem_we", {31'd0, mem_we}, {31'd0, m_we});
         if (m_we) checkOutput("mem_wdata", mem_wdata, m_wdata);
      end
      if (m_in_reset) begin
         checkOutput("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
         checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
         checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
      end
   endtask

   // Memory responder, run just after each rising edge.
   task automatic respond();
      if (mem_ack) begin
         mem_ack = 1'b0;
      end else if (mem_req && !resp_done && ack_delay >= 0) begin
         if (resp_cnt == ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = resp_data;
            resp_done = 1;
         end
         resp_cnt++;
      end
      if (!mem_req) begin
         resp_cnt  = 0;
         resp_done = 0;
      end
   endtask

   // One clock cycle: compare on the falling edge, model on the rising edge,
   // then respond and hand control back 1 time unit after the edge.
   task automatic step();
      @(negedge clk);
      if (cmp_on) compareModel();
      @(posedge clk);
      modelUpdate();
      #1;
      respond();
   endtask

   // Keep each requester asserted until it has completed n transactions,
   // logging completion order from the DUT ready pulses.
   task automatic runTxns(input int n_if, input int n_dm, input logic wr);
      int left_if = n_if;
      int left_dm = n_dm;
      seen_req = 0;
      if_req = (left_if > 0);
      dm_req = (left_dm > 0);
      dm_we  = wr;
      for (int cyc = 0; cyc < 400 && (left_if > 0 || left_dm > 0); cyc++) begin
         step();
         if (mem_req && !seen_req) begin
            seen_req = 1; first_we = mem_we; first_addr = mem_addr;
         end
         if (if_ready) begin
            gnt_log.push_back(0);
            left_if--;
            if (left_if == 0) if_req = 0; else if_addr = if_addr + 16'd1;
            resp_data = resp_data + 32'h0000_0111;
         end
         if (dm_ready) begin
            gnt_log.push_back(1);
            left_dm--;
            if (left_dm == 0) dm_req = 0;
            else begin dm_addr = dm_addr + 16'd1; dm_wdata = dm_wdata + 32'd1; end
            resp_data = resp_data + 32'h0000_0111;
         end
      end
      if (left_if > 0 || left_dm > 0) begin
         n_checks++; n_fail++;
         $display("[TB] FAIL runTxns bound: pending if=%0d dm=%0d, required 0", left_if, left_dm);
         if_req = 0; dm_req = 0;
      end
      repeat (2) step();
   endtask

   int exp_order[7] = '{1, 1, 1, 1, 0, 1, 1};
   int cyc;
   int req_cycles;

   initial begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      mem_ack   = 1'b0;
      mem_rdata = '0;
      rst       = 1'b0;
      step();
      step();
      cmp_on = 1;

      $display("[TB] reset state");
      checkOutput("reset_mem_req", {31'd0, mem_req}, 32'd0);
      checkOutput("reset_if_rdata", if_rdata, 32'd0);
      checkOutput("reset_dm_rdata", dm_rdata, 32'd0);
      checkOutput("reset_err", {31'd0, err_timeout}, 32'd0);
      rst = 1'b1;
      repeat (2) step();

      $display("[TB] single fetch, ack after 2 cycles");
      ack_delay = 2; resp_data = 32'h8C22_0000;
      applyStimulus(1'b1, 16'h0004, 1'b0, 1'b0, '0, '0);
      req_cycles = 0;
      cyc = 0;
      while (cyc < 20) begin
         step(); cyc++;
         if (mem_req) req_cycles++;
         if (if_ready) break;
      end
      checkOutput("t1_latency", cyc, 32'd4);
      checkOutput("t1_mem_req_cycles", req_cycles, 32'd3);
      checkOutput("t1_if_rdata", if_rdata, 32'h8C22_0000);
      if_req = 1'b0;
      checkOutput("t1_stall_if", {31'd0, stall_if}, 32'd0);
      repeat (2) step();

      $display("[TB] simultaneous data write and fetch");
      ack_delay = 0; resp_data = 32'h1111_0000;
      applyStimulus(1'b1, 16'h0008, 1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF);
      gnt_log.delete();
      runTxns(1, 1, 1'b1);
      checkOutput("t2_first_we", {31'd0, first_we}, 32'd1);
      checkOutput("t2_first_addr", {16'd0, first_addr}, 32'h0000_0010);
      checkOutput("t2_order_len", gnt_log.size(), 32'd2);
      if (gnt_log.size() == 2) begin
         checkOutput("t2_order0", gnt_log[0], 32'd1);
         checkOutput("t2_order1", gnt_log[1], 32'd0);
      end
      checkOutput("t2_dm_rdata", dm_rdata, 32'd0);

      $display("[TB] fetch starvation limit");
      ack_delay = 1; resp_data = 32'hA000_0000;
      applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0200, '0);
      gnt_log.delete();
      m_grants.delete();
      runTxns(1, 6, 1'b0);
      checkOutput("t3_order_len", gnt_log.size(), 32'd7);
      checkOutput("t3_model_len", m_grants.size(), 32'd7);
      for (int i = 0; i < 7; i++) begin
         if (i < gnt_log.size()) checkOutput($sformatf("t3_order%0d", i), gnt_log[i], exp_order[i]);
         if (i < m_grants.size()) checkOutput($sformatf("t3_model%0d", i), m_grants[i], exp_order[i]);
      end
      checkOutput("t3_starve_cnt", {29'd0, dut.starve_cnt}, 32'd0);

      $display("[TB] data read timeout");
      ack_delay = -1;
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 16'h0030, '0);
      step();
      checkOutput("t4_mem_req", {31'd0, mem_req}, 32'd1);
      cyc = 0;
      while (cyc < 100) begin
         step(); cyc++;
         if (dm_ready) break;
      end
      checkOutput("t4_timeout_cycles", cyc, 32'd64);
      checkOutput("t4_dm_rdata", dm_rdata, 32'd0);
      checkOutput("t4_err", {31'd0, err_timeout}, 32'd1);
      dm_req = 1'b0;
      repeat (2) step();
      ack_delay = 1; resp_data = 32'h5555_0000;
      applyStimulus(1'b1, 16'h0050, 1'b1, 1'b0, 16'h0060, '0);
      runTxns(1, 1, 1'b0);
      checkOutput("t4_err_sticky", {31'd0, err_timeout}, 32'd1);

      $display("[TB] reset during fetch, stray ack afterwards");
      ack_delay = -1;
      applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0, '0, '0);
      repeat (2) step();
      checkOutput("t5_mem_req_before", {31'd0, mem_req}, 32'd1);
      rst = 1'b0; if_req = 1'b0;
      repeat (2) step();
      checkOutput("t5_rst_mem_req", {31'd0, mem_req}, 32'd0);
      checkOutput("t5_rst_if_rdata", if_rdata, 32'd0);
      checkOutput("t5_rst_dm_rdata", dm_rdata, 32'd0);
      checkOutput("t5_rst_err", {31'd0, err_timeout}, 32'd0);
      rst = 1'b1;
      step();
      mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      step();
      checkOutput("t5_stray_ready", {31'd0, if_ready}, 32'd0);
      checkOutput("t5_stray_req", {31'd0, mem_req}, 32'd0);
      step();
      checkOutput("t5_stray_rdata", if_rdata, 32'd0);
      ack_delay = 2; resp_data = 32'h1234_5678;
      applyStimulus(1'b1, 16'h0044, 1'b0, 1'b0, '0, '0);
      runTxns(1, 0, 1'b0);
      checkOutput("t5_after_if_rdata", if_rdata, 32'h1234_5678);

      $display("[TB] data address change mid-transaction");
      ack_delay = 3; resp_data = 32'h0BAD_CAFE;
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 16'h0020, '0);
      step();
      dm_addr = 16'h0077;
      step();
      checkOutput("t6_mem_addr_a", {16'd0, mem_addr}, 32'h0000_0020);
      step();
      checkOutput("t6_mem_addr_b", {16'd0, mem_addr}, 32'h0000_0020);
      cyc = 0;
      while (cyc < 20 && !dm_ready) begin
         step(); cyc++;
      end
      checkOutput("t6_dm_ready", {31'd0, dm_ready}, 32'd1);
      checkOutput("t6_dm_rdata", dm_rdata, 32'h0BAD_CAFE);
      dm_req = 1'b0;
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
